// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser_pkg
// Purpose  : Shared state encoding, tube indices and default coin values
// Revision : 1.0
// ============================================================================
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_FIRE     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int unsigned c_TUBE_LO  = 0;
    localparam int unsigned c_TUBE_MID = 1;
    localparam int unsigned c_TUBE_HI  = 2;

    localparam logic [7:0] c_DEN_HI_DEFAULT  = 8'd20;
    localparam logic [7:0] c_DEN_MID_DEFAULT = 8'd10;
    localparam logic [7:0] c_DEN_LO_DEFAULT  = 8'd5;

endpackage
`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser_coin_select
// Purpose  : Greedy picker: largest affordable coin whose tube is not empty
// Revision : 1.0
// ============================================================================
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
(
    input  logic [7:0] i_remaining,
    input  logic [3:0] i_cnt_hi,
    input  logic [3:0] i_cnt_mid,
    input  logic [3:0] i_cnt_lo,
    input  logic [7:0] i_den_hi,
    input  logic [7:0] i_den_mid,
    input  logic [7:0] i_den_lo,
    output logic       o_valid,
    output logic [2:0] o_onehot,
    output logic [7:0] o_den
);

    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_den    = '0;
        if (i_remaining >= i_den_hi && i_cnt_hi != 4'd0) begin
            o_valid             = 1'b1;
            o_onehot[c_TUBE_HI] = 1'b1;
            o_den               = i_den_hi;
        end else if (i_remaining >= i_den_mid && i_cnt_mid != 4'd0) begin
            o_valid              = 1'b1;
            o_onehot[c_TUBE_MID] = 1'b1;
            o_den                = i_den_mid;
        end else if (i_remaining >= i_den_lo && i_cnt_lo != 4'd0) begin
            o_valid             = 1'b1;
            o_onehot[c_TUBE_LO] = 1'b1;
            o_den               = i_den_lo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays change greedily from three coin tubes via fire/ack handshake
// Revision : 1.0
// ============================================================================
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter logic [7:0]  DEN_HI      = c_DEN_HI_DEFAULT,
    parameter logic [7:0]  DEN_MID     = c_DEN_MID_DEFAULT,
    parameter logic [7:0]  DEN_LO      = c_DEN_LO_DEFAULT,
    parameter logic [3:0]  TUBE_INIT   = 4'd8,
    parameter int unsigned PULSE_LEN   = 2,
    parameter int unsigned GAP_LEN     = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        change_valid,
    input  logic [7:0]  change_in,
    input  logic        refill,
    input  logic        coin_ack,
    output logic [2:0]  coin_fire,
    output logic        busy,
    output logic        done,
    output logic        short,
    output logic        jam,
    output logic [7:0]  remaining,
    output logic [11:0] tube_cnt
);

    localparam logic [3:0] c_PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0] c_GAP_LAST   = 4'(GAP_LEN - 1);
    localparam logic [3:0] c_ACK_LAST   = 4'(ACK_TIMEOUT - 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [2:0][3:0] r_tube;
    logic [2:0]      r_sel;
    logic [7:0]      r_den;
    logic [7:0]      r_remaining;
    logic [2:0]      r_fire;
    logic            r_busy;
    logic            r_done;
    logic            r_short;
    logic            r_jam;

    logic            w_sel_valid;
    logic [2:0]      w_sel_onehot;
    logic [7:0]      w_sel_den;

    change_dispenser_coin_select u_coin_select (
        .i_remaining (r_remaining),
        .i_cnt_hi    (r_tube[c_TUBE_HI]),
        .i_cnt_mid   (r_tube[c_TUBE_MID]),
        .i_cnt_lo    (r_tube[c_TUBE_LO]),
        .i_den_hi    (DEN_HI),
        .i_den_mid   (DEN_MID),
        .i_den_lo    (DEN_LO),
        .o_valid     (w_sel_valid),
        .o_onehot    (w_sel_onehot),
        .o_den       (w_sel_den)
    );

    // r_cnt is shared: pulse length in FIRE, timeout in WAIT_ACK, spacing in GAP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tube      <= {3{TUBE_INIT}};
            r_sel       <= '0;
            r_den       <= '0;
            r_remaining <= '0;
            r_fire      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_jam       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_short <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (change_valid) begin
                        r_remaining <= change_in;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SELECT;
                    end else if (refill) begin
                        r_tube <= {3{TUBE_INIT}};
                        r_jam  <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (w_sel_valid && r_remaining != 8'd0) begin
                        r_sel   <= w_sel_onehot;
                        r_den   <= w_sel_den;
                        r_fire  <= w_sel_onehot;
                        r_cnt   <= '0;
                        r_state <= ST_FIRE;
                    end else begin
                        r_done  <= 1'b1;
                        r_short <= (r_remaining != 8'd0);
                        r_state <= ST_DONE;
                    end
                end
                ST_FIRE: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        r_fire  <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_ACK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (coin_ack) begin
                        r_remaining <= r_remaining - r_den;
                        for (int i = 0; i < 3; i++) begin
                            if (r_sel[i]) r_tube[i] <= r_tube[i] - 4'd1;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else if (r_cnt == c_ACK_LAST) begin
                        // A silent tube is treated as empty so SELECT falls back to another coin
                        r_jam <= 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            if (r_sel[i]) r_tube[i] <= '0;
                        end
                        r_state <= ST_SELECT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) r_state <= ST_SELECT;
                    else                     r_cnt   <= r_cnt + 4'd1;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign coin_fire = r_fire;
    assign busy      = r_busy;
    assign done      = r_done;
    assign short     = r_short;
    assign jam       = r_jam;
    assign remaining = r_remaining;
    assign tube_cnt  = r_tube;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Scoreboard bench for change_dispenser with a greedy-payout model
// Revision : 1.0
// ============================================================================
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        change_valid;
    logic [7:0]  change_in;
    logic        refill;
    logic        coin_ack;
    logic [2:0]  coin_fire;
    logic        busy;
    logic        done;
    logic        short;
    logic        jam;
    logic [7:0]  remaining;
    logic [11:0] tube_cnt;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .change_valid (change_valid),
        .change_in    (change_in),
        .refill       (refill),
        .coin_ack     (coin_ack),
        .coin_fire    (coin_fire),
        .busy         (busy),
        .done         (done),
        .short        (short),
        .jam          (jam),
        .remaining    (remaining),
        .tube_cnt     (tube_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  rem;
        logic        shrt;
        logic        jam;
        logic [11:0] tubes;
        logic [7:0]  nfire;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] fire_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int  den[3] = '{5, 10, 20};
    int  m_tube[3];
    bit  m_jam;
    int  last_rem;
    bit  ack_plan[64];
    int  att_idx;
    int  issue_cyc;
    bit  lat_pending;
    bit  abort_run;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: greedy payout over the tube inventory, following the ack plan
    task automatic model_txn(input int amt);
        int rem;
        int k;
        int pick;
        bit more;
        exp_t e;
        rem  = amt;
        k    = 0;
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int i = 2; i >= 0; i--)
                if (pick < 0 && den[i] <= rem && m_tube[i] > 0) pick = i;
            if (rem == 0 || pick < 0) begin
                more = 1'b0;
            end else begin
                fire_q.push_back(3'(1 << pick));
                if (ack_plan[k]) begin
                    rem -= den[pick];
                    m_tube[pick]--;
                end else begin
                    m_jam        = 1'b1;
                    m_tube[pick] = 0;
                end
                k++;
            end
        end
        e.rem   = 8'(rem);
        e.shrt  = (rem != 0);
        e.jam   = m_jam;
        e.tubes = {4'(m_tube[2]), 4'(m_tube[1]), 4'(m_tube[0])};
        e.nfire = 8'(k);
        exp_q.push_back(e);
        last_rem = rem;
    endtask

    task automatic wait_idle(input bit glitch);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            if (glitch && $urandom_range(0, 15) == 0) begin
                change_valid = 1'b1;
                change_in    = 8'($urandom);
                refill       = 1'b1;
            end
            @(negedge clk);
            change_valid = 1'b0;
            refill       = 1'b0;
            n++;
        end
        if (busy) begin
            check("idle_timeout", busy, 0);
            abort_run = 1'b1;
        end
    endtask

    // mode 0: every coin acked; 1: first coin never acked; 2: random 90% acks
    task automatic issue(input int amt, input int mode, input bit with_refill);
        check("idle_remaining_hold", remaining, last_rem);
        for (int i = 0; i < 64; i++)
            ack_plan[i] = (mode == 0) ? 1'b1 :
                          (mode == 1) ? (i != 0) : ($urandom_range(0, 9) != 0);
        att_idx = 0;
        model_txn(amt);
        change_valid = 1'b1;
        change_in    = 8'(amt);
        refill       = with_refill;
        issue_cyc    = cyc;
        lat_pending  = 1'b1;
        @(negedge clk);
        change_valid = 1'b0;
        refill       = 1'b0;
        change_in    = 8'($urandom);
    endtask

    task automatic send(input int amt, input int mode, input bit with_refill);
        if (!abort_run) begin
            issue(amt, mode, with_refill);
            wait_idle(mode == 2);
        end
    endtask

    task automatic do_refill();
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        m_tube = '{8, 8, 8};
        m_jam  = 1'b0;
        check("refill_tubes", tube_cnt, 12'h888);
        check("refill_jam", jam, 0);
    endtask

    // Coin mechanism: acks per plan a few cycles into WAIT_ACK, with stray acks during FIRE
    initial begin : mechanism
        logic [2:0] prev;
        int         dly;
        bit         pending;
        prev     = '0;
        dly      = 0;
        pending  = 1'b0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            coin_ack = 1'b0;
            if (pending) begin
                if (dly == 0) begin
                    coin_ack = 1'b1;
                    pending  = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (coin_fire != 0 && prev == 0) begin
                if ($urandom_range(0, 3) == 0) coin_ack = 1'b1;
                att_idx++;
            end
            if (coin_fire == 0 && prev != 0 && att_idx > 0 && ack_plan[att_idx - 1]) begin
                dly = $urandom_range(0, 5);
                if (dly == 0) coin_ack = 1'b1;
                else begin
                    dly--;
                    pending = 1'b1;
                end
            end
            prev = coin_fire;
        end
    end

    initial begin : monitor
        logic [2:0] prev;
        logic [2:0] ef;
        int         plen;
        int         nfire;
        exp_t       e;
        prev  = '0;
        plen  = 0;
        nfire = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev  = '0;
                plen  = 0;
                nfire = 0;
            end else begin
                if (lat_pending && (coin_fire != 0 || done)) begin
                    check("first_event_latency", cyc - issue_cyc, 2);
                    lat_pending = 1'b0;
                end
                if (coin_fire != 0) begin
                    plen++;
                    if (prev == 0) begin
                        check("fire_onehot", int'($onehot(coin_fire)), 1);
                        check("fire_busy", busy, 1);
                        if (fire_q.size() == 0) check("fire_unexpected", coin_fire, 0);
                        else begin
                            ef = fire_q.pop_front();
                            check("fire_coin", coin_fire, ef);
                        end
                        nfire++;
                    end else if (coin_fire != prev) begin
                        check("fire_stable", coin_fire, prev);
                    end
                end else if (prev != 0) begin
                    check("fire_pulse_len", plen, 2);
                    plen = 0;
                end
                if (short && !done) check("short_without_done", short, 0);
                if (done) begin
                    if (exp_q.size() == 0) check("done_unexpected", done, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("done_remaining", remaining, e.rem);
                        check("done_short", short, e.shrt);
                        check("done_jam", jam, e.jam);
                        check("done_tubes", tube_cnt, e.tubes);
                        check("done_coins", nfire, e.nfire);
                        check("done_busy", busy, 1);
                    end
                    nfire = 0;
                end
                prev = coin_fire;
            end
        end
    end

    initial begin : stimulus
        int amt;
        int n;
        int n_done;
        reset_n      = 1'b0;
        change_valid = 1'b0;
        change_in    = '0;
        refill       = 1'b0;
        m_tube       = '{8, 8, 8};
        m_jam        = 1'b0;
        last_rem     = 0;
        att_idx      = 0;
        issue_cyc    = 0;
        lat_pending  = 1'b0;
        abort_run    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_fire", coin_fire, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_short", short, 0);
        check("reset_jam", jam, 0);
        check("reset_remaining", remaining, 0);
        check("reset_tubes", tube_cnt, 12'h888);
        reset_n = 1'b1;
        @(negedge clk);

        send(35, 0, 1'b0);
        send(7, 0, 1'b0);
        send(10, 1, 1'b0);
        send(0, 0, 1'b0);
        send(25, 0, 1'b1);
        if (!abort_run) do_refill();

        for (int t = 0; t < 40 && !abort_run; t++) begin
            if ($urandom_range(0, 4) == 0) do_refill();
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : 5 * int'($urandom_range(0, 24));
            send(amt, 2, ($urandom_range(0, 7) == 0));
        end

        if (!abort_run) begin
            do_refill();
            send(5, 1, 1'b0);
            issue(40, 0, 1'b0);
            n = 0;
            while (coin_fire != 3'b100 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("reset_test_hi_fire", coin_fire, 3'b100);
            reset_n = 1'b0;
            @(negedge clk);
            exp_q.delete();
            fire_q.delete();
            lat_pending = 1'b0;
            m_tube      = '{8, 8, 8};
            m_jam       = 1'b0;
            last_rem    = 0;
            check("midreset_fire", coin_fire, 0);
            check("midreset_busy", busy, 0);
            check("midreset_done", done, 0);
            check("midreset_remaining", remaining, 0);
            check("midreset_tubes", tube_cnt, 12'h888);
            check("midreset_jam", jam, 0);
            @(negedge clk);
            reset_n = 1'b1;
            n_done  = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) n_done++;
            end
            check("midreset_no_done", n_done, 0);
            send(15, 0, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("fire_queue_drained", fire_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
